// File: rtl/mem_responder_pkg.sv
// ============================================================================
//  mem_responder_pkg
//  Shared FSM encoding and default latency for the multi-cycle memory responder.
//  Rev 1.0
// ============================================================================
`default_nettype none

package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int unsigned DEFAULT_LATENCY = 4;
  localparam int unsigned CNT_W           = 4;

endpackage

`default_nettype wire

// File: rtl/mem_responder_if.sv
// ============================================================================
//  mem_responder_if
//  Request/response bundle between the pipeline (master) and the responder.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface mem_responder_if #(
  parameter int DATA_SIZE = 16
);
  logic                 Rd;
  logic                 Wr;
  logic [DATA_SIZE-1:0] Addr;
  logic [DATA_SIZE-1:0] DataIn;
  logic [DATA_SIZE-1:0] DataOut;
  logic                 Stall;
  logic                 Done;
  logic                 Err;

  modport master (
    output Rd, Wr, Addr, DataIn,
    input  DataOut, Stall, Done, Err
  );

  modport slave (
    input  Rd, Wr, Addr, DataIn,
    output DataOut, Stall, Done, Err
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder_lat_counter.sv
// ============================================================================
//  lat_counter
//  Loadable 4-bit down-counter with zero and last-step flags.
//  Rev 1.0
// ============================================================================
`default_nettype none

module lat_counter
  import mem_responder_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [CNT_W-1:0] i_load_val,
  input  wire logic             i_dec,
  output logic                  o_zero,
  output logic                  o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
  assign o_last = (r_cnt == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
//  mem_responder
//  Multi-cycle load/store responder holding Stall while an access is in flight.
//  Rev 1.0
// ============================================================================
`default_nettype none

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = DEFAULT_LATENCY
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mem_responder_if.slave  bus
);

  localparam int               IDX_W  = ADDR_BITS - 1;
  localparam int               WORDS  = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(LATENCY - 1);
  localparam bit               c_FAST = (LATENCY == 1);

  state_t               r_state;
  logic                 r_op_wr;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_SIZE-1:0] r_wdata;
  logic [DATA_SIZE-1:0] r_dout;
  logic                 r_err;
  logic [DATA_SIZE-1:0] r_mem [WORDS];

  logic                 w_idle;
  logic                 w_invalid;
  logic                 w_accept;
  logic [IDX_W-1:0]     w_req_idx;
  logic                 w_cnt_zero;
  logic                 w_cnt_last;
  logic                 w_finish;
  logic                 w_commit;
  logic                 w_c_wr;
  logic [IDX_W-1:0]     w_c_idx;
  logic [DATA_SIZE-1:0] w_c_data;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_invalid = (bus.Rd && bus.Wr) || ((bus.Rd || bus.Wr) && bus.Addr[0]);
  assign w_accept  = w_idle && (bus.Rd || bus.Wr) && !w_invalid;
  assign w_req_idx = bus.Addr[ADDR_BITS-1:1];

  lat_counter u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (c_LOAD),
    .i_dec      (r_state == ST_BUSY),
    .o_zero     (w_cnt_zero),
    .o_last     (w_cnt_last)
  );

  // Leave BUSY on the edge that takes the counter to zero, so Done lands in cycle LATENCY.
  assign w_finish = (r_state == ST_BUSY) && (w_cnt_last || w_cnt_zero);

  // With LATENCY==1 the access completes on the acceptance edge using live request fields.
  assign w_commit = w_finish || (c_FAST && w_accept);
  assign w_c_wr   = w_idle ? bus.Wr     : r_op_wr;
  assign w_c_idx  = w_idle ? w_req_idx  : r_idx;
  assign w_c_data = w_idle ? bus.DataIn : r_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_op_wr <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_idle && w_invalid;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op_wr <= bus.Wr;
            r_idx   <= w_req_idx;
            r_wdata <= bus.DataIn;
            r_state <= c_FAST ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_finish) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WORDS; i++) begin
        r_mem[i] <= '0;
      end
      r_dout <= '0;
    end else if (w_commit) begin
      if (w_c_wr) begin
        r_mem[w_c_idx] <= w_c_data;
      end else begin
        r_dout <= r_mem[w_c_idx];
      end
    end
  end

  assign bus.Stall   = (r_state == ST_BUSY);
  assign bus.Done    = (r_state == ST_DONE);
  assign bus.Err     = r_err;
  assign bus.DataOut = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
//  tb_mem_responder
//  Randomised and directed checks of two responders (LATENCY 4 and 1) against a word-array model.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_SIZE(16)) a_if ();
  mem_responder_if #(.DATA_SIZE(16)) b_if ();

  mem_responder #(.DATA_SIZE(16), .ADDR_BITS(8), .LATENCY(4)) u_dut_a (
    .clk (clk), .rst (rst), .bus (a_if)
  );
  mem_responder #(.DATA_SIZE(16), .ADDR_BITS(8), .LATENCY(1)) u_dut_b (
    .clk (clk), .rst (rst), .bus (b_if)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] model [2][128];
  logic [15:0] held  [2];

  function automatic int lat_of(input int which);
    return (which == 0) ? 4 : 1;
  endfunction

  function automatic logic [15:0] get_out(input int which, input int sel);
    logic [15:0] v;
    v = '0;
    case (sel)
      0: v = (which == 0) ? 16'(a_if.Stall) : 16'(b_if.Stall);
      1: v = (which == 0) ? 16'(a_if.Done)  : 16'(b_if.Done);
      2: v = (which == 0) ? 16'(a_if.Err)   : 16'(b_if.Err);
      default: v = (which == 0) ? a_if.DataOut : b_if.DataOut;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] data);
    if (which == 0) begin
      a_if.Rd = rd; a_if.Wr = wr; a_if.Addr = addr; a_if.DataIn = data;
    end else begin
      b_if.Rd = rd; b_if.Wr = wr; b_if.Addr = addr; b_if.DataIn = data;
    end
  endtask

  task automatic chk_all(input int which, input string tag, input logic stall,
                         input logic done, input logic err, input logic [15:0] dout);
    chk($sformatf("%s.stall", tag), get_out(which, 0), 16'(stall));
    chk($sformatf("%s.done",  tag), get_out(which, 1), 16'(done));
    chk($sformatf("%s.err",   tag), get_out(which, 2), 16'(err));
    chk($sformatf("%s.dout",  tag), get_out(which, 3), dout);
  endtask

  task automatic clear_model();
    for (int w = 0; w < 2; w++) begin
      held[w] = '0;
      for (int i = 0; i < 128; i++) model[w][i] = '0;
    end
  endtask

  // One request in cycle 0 followed by the full expected response window.
  task automatic access(input int which, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [15:0] data, input bit junk);
    int          lat;
    logic [6:0]  idx;
    bit          valid;
    lat   = lat_of(which);
    idx   = addr[7:1];
    valid = (rd ^ wr) && !addr[0];
    drive(which, rd, wr, addr, data);
    if (valid) begin
      for (int k = 1; k <= lat; k++) begin
        @(posedge clk); #1;
        if (k == lat) begin
          if (wr) model[which][idx] = data;
          else    held[which] = model[which][idx];
        end
        chk_all(which, $sformatf("acc%0d.c%0d", which, k), k < lat, k == lat, 1'b0, held[which]);
        if (junk) drive(which, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        16'($urandom), 16'($urandom));
        else      drive(which, 1'b0, 1'b0, 16'h0, 16'h0);
      end
      @(posedge clk); #1;
      drive(which, 1'b0, 1'b0, 16'h0, 16'h0);
      chk_all(which, $sformatf("acc%0d.idle", which), 1'b0, 1'b0, 1'b0, held[which]);
    end else begin
      @(posedge clk); #1;
      drive(which, 1'b0, 1'b0, 16'h0, 16'h0);
      chk_all(which, $sformatf("bad%0d.c1", which), 1'b0, 1'b0, rd | wr, held[which]);
      @(posedge clk); #1;
      chk_all(which, $sformatf("bad%0d.c2", which), 1'b0, 1'b0, 1'b0, held[which]);
    end
  endtask

  initial begin
    logic [15:0] ra;
    int          sel;

    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk_all(0, "reset_a", 1'b0, 1'b0, 1'b0, 16'h0000);
    chk_all(1, "reset_b", 1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b1;
    @(posedge clk); #1;

    access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    chk("store_load", a_if.DataOut, 16'hBEEF);

    access(0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0);
    access(0, 1'b1, 1'b1, 16'h0004, 16'hFFFF, 1'b0);
    access(0, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
    chk("both_asserted", a_if.DataOut, 16'h0000);

    access(0, 1'b0, 1'b1, 16'h0102, 16'h1234, 1'b0);
    access(0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
    chk("wrap", a_if.DataOut, 16'h1234);

    for (int n = 0; n < 80; n++) begin
      ra      = 16'($urandom);
      ra[7:4] = 4'h0;
      ra[0]   = ($urandom_range(0, 7) == 0);
      sel     = $urandom_range(0, 9);
      access((n < 60) ? 0 : 1, sel < 4 || sel == 8, (sel >= 4 && sel < 8) || sel == 8,
             ra, 16'($urandom), 1'b1);
    end

    access(0, 1'b0, 1'b1, 16'h0020, 16'h5555, 1'b0);
    drive(0, 1'b0, 1'b1, 16'h0020, 16'h5555);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rst_mid.c1_stall", 16'(a_if.Stall), 16'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    clear_model();
    chk_all(0, "rst_mid.async", 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_mid.nodone%0d", k), 16'(a_if.Done), 16'h0);
    end
    rst = 1'b1;
    access(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    chk("rst_mid.discard", a_if.DataOut, 16'h0000);

    access(1, 1'b0, 1'b1, 16'h0030, 16'hA5A5, 1'b0);
    drive(1, 1'b1, 1'b0, 16'h0030, 16'h0000);
    @(posedge clk); #1;
    chk_all(1, "hold.c1", 1'b0, 1'b1, 1'b0, 16'hA5A5);
    @(posedge clk); #1;
    chk_all(1, "hold.c2", 1'b0, 1'b0, 1'b0, 16'hA5A5);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    chk_all(1, "hold.c3", 1'b0, 1'b1, 1'b0, 16'hA5A5);
    @(posedge clk); #1;
    chk_all(1, "hold.c4", 1'b0, 1'b0, 1'b0, 16'hA5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
